// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter draining per-slave APB request FIFOs into a single APB3 master port.
// One transfer at a time; completions come back tagged with the FIFO they were popped from.
module apb_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         fifo_empty_i,
    input  logic [NUM_PORTS-1:0]         fifo_write_i,
    input  logic [NUM_PORTS*AW-1:0]      fifo_addr_i,
    input  logic [NUM_PORTS*DW-1:0]      fifo_wdata_i,
    output logic [NUM_PORTS-1:0]         pop_o,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [AW-1:0]                paddr,
    output logic [DW-1:0]                pwdata,
    input  logic                         pready,
    input  logic [DW-1:0]                prdata,
    input  logic                         pslverr,
    output logic                         rsp_valid_o,
    output logic [$clog2(NUM_PORTS)-1:0] rsp_port_o,
    output logic [DW-1:0]                rsp_rdata_o,
    output logic                         rsp_err_o
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state;
    logic [PW-1:0]         last_grant;
    logic [PW-1:0]         grant;
    logic [PW-1:0]         cand;
    logic                  found;
    logic [CW-1:0]         count;
    logic [NUM_PORTS-1:0]  req;
    logic [AW-1:0]         sel_addr;
    logic [DW-1:0]         sel_wdata;
    logic                  sel_write;

    assign req       = ~fifo_empty_i;
    assign sel_addr  = fifo_addr_i[int'(grant)*AW +: AW];
    assign sel_wdata = fifo_wdata_i[int'(grant)*DW +: DW];
    assign sel_write = fifo_write_i[grant];

    // Search starts one past the previous winner so every non-empty FIFO gets its turn.
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(last_grant) + i) % NUM_PORTS);
            if (!found && req[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // Pop is gated by reset so an async reset never leaves a strobe toward a FIFO.
    always_comb begin
        pop_o = '0;
        if (reset && (state == IDLE) && (|req)) begin
            pop_o[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_grant  <= PW'(NUM_PORTS - 1);
            count       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_port_o  <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        last_grant <= grant;
                        paddr      <= sel_addr;
                        pwrite     <= sel_write;
                        pwdata     <= sel_write ? sel_wdata : '0;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    count <= count + CW'(1);
                    // pready wins over the timeout when both land on the same cycle.
                    if (pready) begin
                        rsp_rdata_o <= pwrite ? '0 : prdata;
                        rsp_err_o   <= pslverr;
                        rsp_port_o  <= last_grant;
                        rsp_valid_o <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        rsp_port_o  <= last_grant;
                        rsp_valid_o <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: behavioural FIFOs and APB slave around the DUT,
// expected grants/APB phases/completions queued by hand per directed test.
module tb_apb_rr_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        int          port;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          len;
    } rsp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NP-1:0]         fifo_empty;
    logic [NP-1:0]         fifo_write;
    logic [NP*AW-1:0]      fifo_addr;
    logic [NP*DW-1:0]      fifo_wdata;
    logic [NP-1:0]         pop;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [AW-1:0]         paddr;
    logic [DW-1:0]         pwdata;
    logic                  pready;
    logic [DW-1:0]         prdata;
    logic                  pslverr;
    logic                  rsp_valid;
    logic [1:0]            rsp_port;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_err;

    req_t        fq [NP][$];
    int          exp_grant_q[$];
    req_t        exp_apb_q[$];
    rsp_t        exp_rsp_q[$];
    req_t        cur_apb;
    req_t        fe;
    rsp_t        rr;
    int          eg;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wait_cycles = 0;
    logic [31:0] rd_data = 32'h1234_5678;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;
    int          last_len = 0;
    bit          check_gaps = 1'b0;
    int          last_rsp_cyc = -1;

    apb_rr_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty),
        .fifo_write_i (fifo_write),
        .fifo_addr_i  (fifo_addr),
        .fifo_wdata_i (fifo_wdata),
        .pop_o        (pop),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pready       (pready),
        .prdata       (prdata),
        .pslverr      (pslverr),
        .rsp_valid_o  (rsp_valid),
        .rsp_port_o   (rsp_port),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=present expected=none at cycle %0d", name, cyc);
    endtask

    task automatic push_req(input int port, input logic write, input logic [31:0] addr, input logic [31:0] wdata);
        req_t e;
        e.port  = port;
        e.write = write;
        e.addr  = addr;
        e.wdata = wdata;
        fq[port].push_back(e);
    endtask

    task automatic expect_txn(input int port, input logic write, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int len, input bit has_rsp);
        req_t a;
        rsp_t r;
        a.port  = port;
        a.write = write;
        a.addr  = addr;
        a.wdata = wdata;
        exp_grant_q.push_back(port);
        exp_apb_q.push_back(a);
        if (has_rsp) begin
            r.port  = port;
            r.rdata = rdata;
            r.err   = err;
            r.len   = len;
            exp_rsp_q.push_back(r);
        end
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (exp_rsp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output("rsp_drain", exp_rsp_q.size(), 0);
        repeat (2) @(negedge clk);
        check_output("grants_left", exp_grant_q.size(), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // FIFO model: the posedge that sees a pop strobe retires the head entry.
    always @(posedge clk) begin
        cyc++;
        if (pop != '0) begin
            check_output("pop_onehot", $countones(pop), 1);
            for (int p = 0; p < NP; p++) begin
                if (pop[p]) begin
                    check_output("pop_nonempty", fq[p].size() != 0, 1);
                    if (fq[p].size() != 0) void'(fq[p].pop_front());
                    if (exp_grant_q.size() == 0) begin
                        report_unexpected("grant_unexpected");
                    end else begin
                        eg = exp_grant_q.pop_front();
                        check_output("grant_port", p, eg);
                    end
                end
            end
        end
    end

    // Slave responder, APB/response monitors and FIFO output drive, all sampled mid-cycle.
    always @(negedge clk) begin
        if (psel && penable) begin
            acc_cnt++;
            pready = (acc_cnt > wait_cycles);
        end else begin
            if (acc_cnt != 0) last_len = acc_cnt;
            acc_cnt = 0;
            pready  = 1'b0;
        end
        prdata  = rd_data;
        pslverr = slv_err;

        if (psel && !penable) begin
            if (exp_apb_q.size() == 0) begin
                report_unexpected("setup_unexpected");
            end else begin
                cur_apb = exp_apb_q.pop_front();
                check_output("setup_pwrite", pwrite, cur_apb.write);
                check_output("setup_paddr", paddr, cur_apb.addr);
                check_output("setup_pwdata", pwdata, cur_apb.wdata);
            end
        end else if (psel && penable) begin
            check_output("access_paddr", paddr, cur_apb.addr);
            check_output("access_pwdata", pwdata, cur_apb.wdata);
        end

        if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
                report_unexpected("rsp_unexpected");
            end else begin
                rr = exp_rsp_q.pop_front();
                check_output("rsp_port", rsp_port, rr.port);
                check_output("rsp_rdata", rsp_rdata, rr.rdata);
                check_output("rsp_err", rsp_err, rr.err);
                check_output("access_len", last_len, rr.len);
                if (check_gaps && last_rsp_cyc >= 0) check_output("rsp_gap", cyc - last_rsp_cyc, 4);
                last_rsp_cyc = cyc;
            end
        end

        for (int p = 0; p < NP; p++) begin
            fifo_empty[p] = (fq[p].size() == 0);
            if (fq[p].size() != 0) begin
                fe = fq[p][0];
                fifo_write[p]             = fe.write;
                fifo_addr[p*AW +: AW]     = fe.addr;
                fifo_wdata[p*DW +: DW]    = fe.wdata;
            end else begin
                fifo_write[p]             = 1'b0;
                fifo_addr[p*AW +: AW]     = '0;
                fifo_wdata[p*DW +: DW]    = '0;
            end
        end
    end

    initial begin
        int n;
        fifo_empty = '1;
        fifo_write = '0;
        fifo_addr  = '0;
        fifo_wdata = '0;
        pready     = 1'b0;
        prdata     = '0;
        pslverr    = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_psel", psel, 0);
        check_output("reset_penable", penable, 0);
        check_output("reset_pop", pop, 0);
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_paddr", paddr, 0);
        reset = 1'b1;

        // single write from port 2, immediate pready
        @(negedge clk);
        wait_cycles = 0;
        expect_txn(2, 1'b1, 32'h100, 32'hCAFE, 32'h0, 1'b0, 1, 1'b1);
        push_req(2, 1'b1, 32'h100, 32'hCAFE);
        wait_done(100);

        // two requests in every FIFO after reset: grants 0,1,2,3,0,1,2,3 back to back
        apply_reset();
        check_gaps   = 1'b1;
        last_rsp_cyc = -1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                if (p % 2 == 0) begin
                    expect_txn(p, 1'b1, 32'h200 + p*16 + r*4, 32'hA000 + p*16 + r, 32'h0, 1'b0, 1, 1'b1);
                    push_req(p, 1'b1, 32'h200 + p*16 + r*4, 32'hA000 + p*16 + r);
                end else begin
                    expect_txn(p, 1'b0, 32'h200 + p*16 + r*4, 32'h0, 32'h1234_5678, 1'b0, 1, 1'b1);
                    push_req(p, 1'b0, 32'h200 + p*16 + r*4, 32'h5555_5555);
                end
            end
        end
        wait_done(200);
        check_gaps = 1'b0;

        // read from port 1 with three wait states
        wait_cycles = 3;
        rd_data     = 32'hDEAD_BEEF;
        expect_txn(1, 1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, 1'b1);
        push_req(1, 1'b0, 32'h300, 32'h5555_5555);
        wait_done(100);

        // slave never answers: forced error after exactly TIMEOUT access cycles
        wait_cycles = 1000;
        rd_data     = 32'hFFFF_0000;
        expect_txn(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 16, 1'b1);
        push_req(0, 1'b0, 32'h400, 32'h0);
        wait_done(100);

        // slave error on a write, then arbitration continues from port 2
        wait_cycles = 0;
        slv_err     = 1'b1;
        rd_data     = 32'h1234_5678;
        expect_txn(2, 1'b1, 32'h500, 32'hBAD, 32'h0, 1'b1, 1, 1'b1);
        push_req(2, 1'b1, 32'h500, 32'hBAD);
        wait_done(100);
        slv_err = 1'b0;
        expect_txn(3, 1'b1, 32'h504, 32'h11, 32'h0, 1'b0, 1, 1'b1);
        expect_txn(1, 1'b0, 32'h508, 32'h0, 32'h1234_5678, 1'b0, 1, 1'b1);
        push_req(1, 1'b0, 32'h508, 32'h0);
        push_req(3, 1'b1, 32'h504, 32'h11);
        wait_done(100);

        // reset during ACCESS aborts silently; port 0 regains priority afterwards
        wait_cycles = 1000;
        expect_txn(1, 1'b0, 32'h600, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        push_req(1, 1'b0, 32'h600, 32'h0);
        n = 0;
        while (!(psel && penable) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("reached_access", psel && penable, 1);
        push_req(3, 1'b1, 32'h700, 32'h77);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_output("abort_psel", psel, 0);
        check_output("abort_penable", penable, 0);
        check_output("abort_pop", pop, 0);
        check_output("abort_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        wait_cycles = 0;
        expect_txn(0, 1'b1, 32'h800, 32'h88, 32'h0, 1'b0, 1, 1'b1);
        expect_txn(2, 1'b0, 32'h900, 32'h0, 32'h1234_5678, 1'b0, 1, 1'b1);
        expect_txn(3, 1'b1, 32'h700, 32'h77, 32'h0, 1'b0, 1, 1'b1);
        push_req(0, 1'b1, 32'h800, 32'h88);
        push_req(2, 1'b0, 32'h900, 32'h9999);
        @(negedge clk);
        #1 reset = 1'b1;
        wait_done(100);

        check_output("apb_left", exp_apb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
